// File: rtl/data_mem_ctrl.sv
// Handshaked data-memory controller: wait states, byte/half/word access, alignment and range errors.
// Optional debug probe of low words enabled by defining DMEM_PROBE_EN.
module data_mem_ctrl #(
    parameter int ADDR_W      = 11,
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_CYCLES = 1,
    parameter int PROBE_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              mem_ready,
    output logic              mem_err,
    input  logic [PROBE_W-1:0] SW,
    output logic [31:0]       SRAMProbe
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

    state_t              state_r;
    logic [2:0]          cnt_r;
    logic                we_r;
    logic [1:0]          size_r;
    logic                uns_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [31:0]         mem_r [DEPTH_WORDS];

    logic                req_err_s;
    logic                wr_en_s;
    logic [MEM_AW-1:0]   idx_s;

    // Replace only the addressed little-endian byte lanes of a stored word
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] wd,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = old_word;
        case (size)
            2'b00:   res[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wd[15:0];
            2'b10:   res = wd;
            default: res = old_word;
        endcase
        return res;
    endfunction

    // Pick the addressed byte/half out of a word and sign- or zero-extend it
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = word[{lane, 3'b000} +: 8];
        h   = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Acceptance-time error classification of the incoming request
    always_comb begin
        req_err_s = 1'b0;
        if (mem_size == 2'b11) begin
            req_err_s = 1'b1;
        end else if ((mem_size == 2'b01 && address[0]) ||
                     (mem_size == 2'b10 && address[1:0] != 2'b00)) begin
            req_err_s = 1'b1;
        end else if ({1'b0, address[ADDR_W-1:2]} >= DEPTH_L) begin
            req_err_s = 1'b1;
        end else begin
            req_err_s = 1'b0;
        end
    end

    // Range check guarantees the truncated index is in bounds; reset blocks a same-edge commit
    assign idx_s   = MEM_AW'(addr_r[ADDR_W-1:2]);
    assign wr_en_s = !reset && (state_r == BUSY) && (cnt_r == 3'd0) && we_r;

    // Control FSM with registered handshake and load result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 3'd0;
            we_r      <= 1'b0;
            size_r    <= 2'b00;
            uns_r     <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= 32'h0;
            readData  <= 32'h0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mem_req) begin
                        we_r    <= mem_we;
                        size_r  <= mem_size;
                        uns_r   <= mem_unsigned;
                        addr_r  <= address;
                        wdata_r <= writeData;
                        if (req_err_s) begin
                            state_r <= ERR;
                        end else begin
                            state_r <= BUSY;
                            cnt_r   <= 3'(WAIT_CYCLES);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r != 3'd0) begin
                        cnt_r <= cnt_r - 3'd1;
                    end else begin
                        if (!we_r) begin
                            readData <= load_extract(mem_r[idx_s], size_r, addr_r[1:0], uns_r);
                        end
                        mem_ready <= 1'b1;
                        state_r   <= RESP;
                    end
                end
                ERR: begin
                    readData  <= 32'h0;
                    mem_ready <= 1'b1;
                    mem_err   <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Store port: merged byte lanes, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= merge_lanes(mem_r[idx_s], wdata_r, size_r, addr_r[1:0]);
        end
    end

`ifdef DMEM_PROBE_EN
    // Debug probe samples pre-write contents of the selected word
    always_ff @(posedge clk) begin
        if (reset) begin
            SRAMProbe <= 32'h0;
        end else if (32'(SW) < 32'(DEPTH_WORDS)) begin
            SRAMProbe <= mem_r[MEM_AW'(SW)];
        end else begin
            SRAMProbe <= 32'h0;
        end
    end
`else
    logic unused_sw_s;
    assign unused_sw_s = ^SW;
    assign SRAMProbe   = 32'h0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances (WAIT 1/3/0) cover latency, lanes, errors, reset abort and throughput.
module tb_data_mem_ctrl;

    logic             clk;
    logic [2:0]       reset_v;
    logic [2:0]       mem_req_v;
    logic [2:0]       mem_we_v;
    logic [2:0][1:0]  mem_size_v;
    logic [2:0]       mem_unsigned_v;
    logic [2:0][10:0] address_v;
    logic [2:0][31:0] writeData_v;
    logic [2:0][31:0] readData_v;
    logic [2:0]       mem_ready_v;
    logic [2:0]       mem_err_v;
    logic [2:0][4:0]  SW_v;
    logic [2:0][31:0] SRAMProbe_v;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        data_mem_ctrl #(
            .ADDR_W      (11),
            .DEPTH_WORDS ((k == 2) ? 256 : 512),
            .WAIT_CYCLES ((k == 0) ? 1 : ((k == 1) ? 3 : 0)),
            .PROBE_W     (5)
        ) u_dut (
            .clk          (clk),
            .reset        (reset_v[k]),
            .mem_req      (mem_req_v[k]),
            .mem_we       (mem_we_v[k]),
            .mem_size     (mem_size_v[k]),
            .mem_unsigned (mem_unsigned_v[k]),
            .address      (address_v[k]),
            .writeData    (writeData_v[k]),
            .readData     (readData_v[k]),
            .mem_ready    (mem_ready_v[k]),
            .mem_err      (mem_err_v[k]),
            .SW           (SW_v[k]),
            .SRAMProbe    (SRAMProbe_v[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request from IDLE; returns load data, edges from acceptance to ready, and error flag
    task automatic access(input int k, input logic we, input logic [1:0] size, input logic uns,
                          input logic [10:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int edges, output logic err);
        mem_req_v[k]      = 1'b1;
        mem_we_v[k]       = we;
        mem_size_v[k]     = size;
        mem_unsigned_v[k] = uns;
        address_v[k]      = addr;
        writeData_v[k]    = wd;
        @(posedge clk); #1;
        mem_req_v[k]   = 1'b0;
        mem_we_v[k]    = ~we;
        address_v[k]   = ~addr;
        writeData_v[k] = ~wd;
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (mem_ready_v[k]) begin
                edges = i;
                break;
            end
        end
        rd  = readData_v[k];
        err = mem_err_v[k];
        @(posedge clk); #1;
        chk("ready_single_cycle", {31'b0, mem_ready_v[k]}, 32'h0);
    endtask

    task automatic wr(input int k, input logic [1:0] size, input logic [10:0] addr,
                      input logic [31:0] wd, input int exp_edges, input string tag);
        logic [31:0] rd;
        int          e;
        logic        err;
        access(k, 1'b1, size, 1'b0, addr, wd, rd, e, err);
        chk({tag, "_latency"}, 32'(e), 32'(exp_edges));
        chk({tag, "_err"}, {31'b0, err}, 32'h0);
    endtask

    task automatic rd_chk(input int k, input logic [1:0] size, input logic uns, input logic [10:0] addr,
                          input logic [31:0] exp, input int exp_edges, input string tag);
        logic [31:0] rd;
        int          e;
        logic        err;
        access(k, 1'b0, size, uns, addr, 32'h0, rd, e, err);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_latency"}, 32'(e), 32'(exp_edges));
        chk({tag, "_err"}, {31'b0, err}, 32'h0);
    endtask

    task automatic err_chk(input int k, input logic we, input logic [1:0] size,
                           input logic [10:0] addr, input string tag);
        logic [31:0] rd;
        int          e;
        logic        err;
        access(k, we, size, 1'b0, addr, 32'hFFFF_FFFF, rd, e, err);
        chk({tag, "_latency"}, 32'(e), 32'd1);
        chk({tag, "_err"}, {31'b0, err}, 32'h1);
        chk({tag, "_rdata"}, rd, 32'h0);
    endtask

    logic [31:0] probe_exp;
    int          t_ready [3];
    int          n_seen;
    int          edge_no;
    int          pulses;

    initial begin
        reset_v        = 3'b111;
        mem_req_v      = 3'b000;
        mem_we_v       = 3'b000;
        mem_unsigned_v = 3'b000;
        mem_size_v     = '0;
        address_v      = '0;
        writeData_v    = '0;
        SW_v           = '0;
        SW_v[0]        = 5'd4;
        repeat (3) @(posedge clk);
        #1;
        reset_v = 3'b000;

        for (int k = 0; k < 3; k++) begin
            chk("reset_readData", readData_v[k], 32'h0);
            chk("reset_ready", {31'b0, mem_ready_v[k]}, 32'h0);
            chk("reset_err", {31'b0, mem_err_v[k]}, 32'h0);
            chk("reset_probe", SRAMProbe_v[k], 32'h0);
        end

        // Word round trip and probe on instance 0 (WAIT_CYCLES=1)
        wr(0, 2'b10, 11'h010, 32'hDEAD_BEEF, 2, "w_word010");
`ifdef DMEM_PROBE_EN
        probe_exp = 32'hDEAD_BEEF;
`else
        probe_exp = 32'h0;
`endif
        chk("probe_word4", SRAMProbe_v[0], probe_exp);
        rd_chk(0, 2'b10, 1'b0, 11'h010, 32'hDEAD_BEEF, 2, "r_word010");

        // Byte merge; upper writeData bits must not leak into other lanes
        wr(0, 2'b10, 11'h020, 32'h0000_0000, 2, "w_word020");
        chk("write_keeps_readData", readData_v[0], 32'hDEAD_BEEF);
        wr(0, 2'b00, 11'h022, 32'h5555_55AB, 2, "w_byte022");
        rd_chk(0, 2'b10, 1'b0, 11'h020, 32'h00AB_0000, 2, "r_merge020");

        // Extension
        wr(0, 2'b00, 11'h031, 32'h0000_0080, 2, "w_byte031");
        rd_chk(0, 2'b00, 1'b0, 11'h031, 32'hFFFF_FF80, 2, "r_sbyte031");
        rd_chk(0, 2'b00, 1'b1, 11'h031, 32'h0000_0080, 2, "r_ubyte031");
        wr(0, 2'b01, 11'h032, 32'h0000_8001, 2, "w_half032");
        rd_chk(0, 2'b01, 1'b0, 11'h032, 32'hFFFF_8001, 2, "r_shalf032");
        rd_chk(0, 2'b01, 1'b1, 11'h032, 32'h0000_8001, 2, "r_uhalf032");

        // Errors leave memory untouched and clear readData
        wr(0, 2'b10, 11'h004, 32'h1122_3344, 2, "w_word004");
        rd_chk(0, 2'b00, 1'b1, 11'h005, 32'h0000_0033, 2, "r_ubyte005");
        err_chk(0, 1'b0, 2'b01, 11'h005, "e_half005");
        err_chk(0, 1'b1, 2'b10, 11'h7FE, "e_word7fe");
        err_chk(0, 1'b1, 2'b11, 11'h004, "e_size11");
        rd_chk(0, 2'b10, 1'b0, 11'h004, 32'h1122_3344, 2, "r_word004_after_err");

        // Reset on the commit edge of a WAIT_CYCLES=3 write (instance 1)
        wr(1, 2'b10, 11'h040, 32'hCAFE_F00D, 4, "w3_word040");
        rd_chk(1, 2'b10, 1'b0, 11'h040, 32'hCAFE_F00D, 4, "r3_word040");
        mem_req_v[1]   = 1'b1;
        mem_we_v[1]    = 1'b1;
        mem_size_v[1]  = 2'b10;
        address_v[1]   = 11'h040;
        writeData_v[1] = 32'h1234_5678;
        @(posedge clk); #1;
        mem_req_v[1] = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_ready_v[1]) pulses++;
        end
        reset_v[1] = 1'b1;
        @(posedge clk); #1;
        reset_v[1] = 1'b0;
        chk("rst_abort_ready", {31'b0, mem_ready_v[1]}, 32'h0);
        chk("rst_abort_err", {31'b0, mem_err_v[1]}, 32'h0);
        chk("rst_abort_readData", readData_v[1], 32'h0);
        repeat (6) begin
            @(posedge clk); #1;
            if (mem_ready_v[1]) pulses++;
        end
        chk("rst_abort_no_pulse", 32'(pulses), 32'd0);
        rd_chk(1, 2'b10, 1'b0, 11'h040, 32'hCAFE_F00D, 4, "r3_word040_kept");

        // Range boundary and back-to-back throughput on instance 2 (WAIT_CYCLES=0, 256 words)
        wr(2, 2'b10, 11'h3FC, 32'hA5A5_0001, 1, "w0_word3fc");
        err_chk(2, 1'b0, 2'b10, 11'h400, "e0_range400");
        rd_chk(2, 2'b10, 1'b0, 11'h3FC, 32'hA5A5_0001, 1, "r0_word3fc");
        wr(2, 2'b10, 11'h100, 32'h1000_0001, 1, "w0_word100");
        wr(2, 2'b10, 11'h104, 32'h1000_0002, 1, "w0_word104");
        wr(2, 2'b10, 11'h108, 32'h1000_0003, 1, "w0_word108");
        mem_req_v[2]      = 1'b1;
        mem_we_v[2]       = 1'b0;
        mem_size_v[2]     = 2'b10;
        mem_unsigned_v[2] = 1'b0;
        address_v[2]      = 11'h100;
        n_seen = 0;
        for (edge_no = 1; edge_no <= 30; edge_no++) begin
            @(posedge clk); #1;
            if (mem_ready_v[2]) begin
                t_ready[n_seen] = edge_no;
                chk("b2b_data", readData_v[2], 32'h1000_0001 + 32'(n_seen));
                n_seen++;
                address_v[2] = address_v[2] + 11'd4;
                if (n_seen == 3) break;
            end
        end
        mem_req_v[2] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_count", 32'(n_seen), 32'd3);
        if (n_seen == 3) begin
            chk("b2b_first", 32'(t_ready[0]), 32'd2);
            chk("b2b_gap1", 32'(t_ready[1] - t_ready[0]), 32'd3);
            chk("b2b_gap2", 32'(t_ready[2] - t_ready[1]), 32'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
